// File: rtl/dram16x4_wr_sched.sv
// Purpose: two-requester round-robin write scheduler for a 16x4 RAM, with optional post-reset clear sweep.
// Latency: an accepted request appears on WAD/WD with WRE=1 one clock later; clearing takes 16 clocks.
// Backpressure: A_READY/B_READY are combinational; losers hold their request, nothing is buffered.
module dram16x4_wr_sched #(
    parameter logic       INIT_EN  = 1'b1,
    parameter logic [3:0] INIT_VAL = 4'h0
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       A_VALID,
    input  logic [3:0] A_ADDR,
    input  logic [3:0] A_DATA,
    output logic       A_READY,
    input  logic       B_VALID,
    input  logic [3:0] B_ADDR,
    input  logic [3:0] B_DATA,
    output logic       B_READY,
    output logic [3:0] WAD,
    output logic [3:0] WD,
    output logic       WRE,
    output logic       BUSY,
    output logic       LAST_B
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic [3:0] wad_nxt;
    logic [3:0] wd_nxt;
    logic       wre_nxt;
    logic       last_b_nxt;
    logic       grant_a;
    logic       grant_b;

    // Round-robin arbitration: on a tie the requester that did not win last time goes first.
    // RSTN gating keeps both READYs low while reset is held, even when INIT_EN=0 parks us in RUN.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (RSTN && (state == RUN)) begin
            if (A_VALID && (!B_VALID || LAST_B)) begin
                grant_a = 1'b1;
            end else if (B_VALID) begin
                grant_b = 1'b1;
            end
        end
    end

    assign A_READY = grant_a;
    assign B_READY = grant_b;
    assign BUSY    = (state == CLEAR);

    // Next-state and next-output logic for the clear sweep and the write path.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        wad_nxt    = WAD;
        wd_nxt     = WD;
        wre_nxt    = 1'b0;
        last_b_nxt = LAST_B;
        case (state)
            CLEAR: begin
                wre_nxt = 1'b1;
                wad_nxt = cnt;
                wd_nxt  = INIT_VAL;
                // cnt parks at 15 on the final sweep write instead of wrapping.
                if (cnt == 4'hF) begin
                    state_nxt = RUN;
                end else begin
                    cnt_nxt = cnt + 4'h1;
                end
            end
            RUN: begin
                if (grant_a) begin
                    wre_nxt    = 1'b1;
                    wad_nxt    = A_ADDR;
                    wd_nxt     = A_DATA;
                    last_b_nxt = 1'b0;
                end else if (grant_b) begin
                    wre_nxt    = 1'b1;
                    wad_nxt    = B_ADDR;
                    wd_nxt     = B_DATA;
                    last_b_nxt = 1'b1;
                end
            end
        endcase
    end

    // State and output registers; reset drops any pending write and re-arms the sweep at address 0.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state  <= INIT_EN ? CLEAR : RUN;
            cnt    <= 4'h0;
            WAD    <= 4'h0;
            WD     <= 4'h0;
            WRE    <= 1'b0;
            LAST_B <= 1'b1;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            WAD    <= wad_nxt;
            WD     <= wd_nxt;
            WRE    <= wre_nxt;
            LAST_B <= last_b_nxt;
        end
    end

endmodule

// File: tb/tb_dram16x4_wr_sched.sv
module tb_dram16x4_wr_sched;

    localparam logic       EN1  = 1'b1;
    localparam logic [3:0] IV1  = 4'hA;
    localparam logic       EN0  = 1'b0;
    localparam logic [3:0] IV0  = 4'h0;

    logic       clk;
    logic       rstn_v [2];
    logic       a_vld, b_vld;
    logic [3:0] a_addr, a_dat, b_addr, b_dat;
    logic       a_rdy_o [2];
    logic       b_rdy_o [2];
    logic [3:0] wad_o [2];
    logic [3:0] wd_o [2];
    logic       wre_o [2];
    logic       busy_o [2];
    logic       lb_o [2];

    int tests = 0;
    int fails = 0;

    // Reference model: per instance, number of sweep writes issued and the last write seen on the RAM port.
    logic       m_clr [2];
    int         m_n [2];
    logic       m_wre [2];
    logic [3:0] m_wad [2];
    logic [3:0] m_wd [2];
    logic       m_lb [2];
    logic       m_ga [2];
    logic       m_gb [2];

    dram16x4_wr_sched #(.INIT_EN(EN0), .INIT_VAL(IV0)) dut0 (
        .CLK(clk), .RSTN(rstn_v[0]),
        .A_VALID(a_vld), .A_ADDR(a_addr), .A_DATA(a_dat), .A_READY(a_rdy_o[0]),
        .B_VALID(b_vld), .B_ADDR(b_addr), .B_DATA(b_dat), .B_READY(b_rdy_o[0]),
        .WAD(wad_o[0]), .WD(wd_o[0]), .WRE(wre_o[0]), .BUSY(busy_o[0]), .LAST_B(lb_o[0])
    );

    dram16x4_wr_sched #(.INIT_EN(EN1), .INIT_VAL(IV1)) dut1 (
        .CLK(clk), .RSTN(rstn_v[1]),
        .A_VALID(a_vld), .A_ADDR(a_addr), .A_DATA(a_dat), .A_READY(a_rdy_o[1]),
        .B_VALID(b_vld), .B_ADDR(b_addr), .B_DATA(b_dat), .B_READY(b_rdy_o[1]),
        .WAD(wad_o[1]), .WD(wd_o[1]), .WRE(wre_o[1]), .BUSY(busy_o[1]), .LAST_B(lb_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic inst_en(input int i);
        return (i == 1) ? EN1 : EN0;
    endfunction

    function automatic logic [3:0] inst_iv(input int i);
        return (i == 1) ? IV1 : IV0;
    endfunction

    task automatic chk(input string tag, input int i, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s dut%0d observed=%h expected=%h at %0t", tag, i, obs, exp, $time);
        end
    endtask

    task automatic model_reset(input int i);
        m_clr[i] = inst_en(i);
        m_n[i]   = 0;
        m_wre[i] = 1'b0;
        m_wad[i] = 4'h0;
        m_wd[i]  = 4'h0;
        m_lb[i]  = 1'b1;
    endtask

    // Expected grant {b,a}: nobody while in reset or sweeping; a lone requester wins; ties alternate.
    function automatic logic [1:0] exp_grant(input int i);
        if (!rstn_v[i] || m_clr[i]) return 2'b00;
        if (a_vld && b_vld) return m_lb[i] ? 2'b01 : 2'b10;
        return {b_vld, a_vld};
    endfunction

    task automatic model_step(input int i);
        logic [1:0] g;
        g = exp_grant(i);
        m_ga[i] = g[0];
        m_gb[i] = g[1];
        if (!rstn_v[i]) begin
            model_reset(i);
        end else if (m_clr[i]) begin
            m_wre[i] = 1'b1;
            m_wad[i] = 4'(m_n[i]);
            m_wd[i]  = inst_iv(i);
            m_n[i]   = m_n[i] + 1;
            if (m_n[i] == 16) m_clr[i] = 1'b0;
        end else if (g[0]) begin
            m_wre[i] = 1'b1; m_wad[i] = a_addr; m_wd[i] = a_dat; m_lb[i] = 1'b0;
        end else if (g[1]) begin
            m_wre[i] = 1'b1; m_wad[i] = b_addr; m_wd[i] = b_dat; m_lb[i] = 1'b1;
        end else begin
            m_wre[i] = 1'b0;
        end
    endtask

    task automatic check_inst(input int i);
        logic [1:0] g;
        g = exp_grant(i);
        chk("a_ready", i, {3'b0, a_rdy_o[i]}, {3'b0, g[0]});
        chk("b_ready", i, {3'b0, b_rdy_o[i]}, {3'b0, g[1]});
        chk("wre",     i, {3'b0, wre_o[i]},   {3'b0, m_wre[i]});
        chk("busy",    i, {3'b0, busy_o[i]},  {3'b0, m_clr[i]});
        chk("last_b",  i, {3'b0, lb_o[i]},    {3'b0, m_lb[i]});
        chk("wad",     i, wad_o[i], m_wad[i]);
        chk("wd",      i, wd_o[i],  m_wd[i]);
    endtask

    // One clock: check both instances mid-cycle, advance the model, leave inputs drivable just after the edge.
    task automatic cycle();
        @(negedge clk);
        for (int i = 0; i < 2; i++) check_inst(i);
        for (int i = 0; i < 2; i++) model_step(i);
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic v, input logic [3:0] ad, input logic [3:0] d);
        a_vld = v; a_addr = ad; a_dat = d;
    endtask

    task automatic set_b(input logic v, input logic [3:0] ad, input logic [3:0] d);
        b_vld = v; b_addr = ad; b_dat = d;
    endtask

    initial begin
        rstn_v[0] = 1'b0;
        rstn_v[1] = 1'b0;
        set_a(1'b1, 4'h0, 4'h0);
        set_b(1'b1, 4'h0, 4'h0);
        model_reset(0);
        model_reset(1);
        @(posedge clk);
        #1;
        // Reset state of both instances, with requests pending.
        cycle();
        cycle();

        // Sweep on dut1 with both requesters asking: 16 writes of A to 0..15, no READY.
        rstn_v[1] = 1'b1;
        for (int k = 0; k < 16; k++) cycle();

        // A alone, address 3 data 5.
        set_a(1'b1, 4'h3, 4'h5);
        set_b(1'b0, 4'h0, 4'h0);
        cycle();
        chk("req040_wad", 1, wad_o[1], 4'h3);
        chk("req040_wd",  1, wd_o[1],  4'h5);
        chk("req040_wre", 1, {3'b0, wre_o[1]}, 4'h1);
        chk("req040_lb",  1, {3'b0, lb_o[1]},  4'h0);

        // B alone so that A wins the following tie, then both target address 7.
        set_a(1'b0, 4'h0, 4'h0);
        set_b(1'b1, 4'h2, 4'h4);
        cycle();
        set_a(1'b1, 4'h7, 4'h1);
        set_b(1'b1, 4'h7, 4'h2);
        cycle();
        chk("req042_first", 1, wd_o[1], 4'h1);
        set_a(1'b0, 4'h0, 4'h0);
        cycle();
        chk("req042_second_wad", 1, wad_o[1], 4'h7);
        chk("req042_second_wd",  1, wd_o[1],  4'h2);
        set_b(1'b0, 4'h0, 4'h0);
        cycle();

        // Random traffic; a request that was not granted is held unchanged.
        for (int k = 0; k < 300; k++) begin
            if (!a_vld || m_ga[1]) set_a($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom));
            if (!b_vld || m_gb[1]) set_b($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom));
            cycle();
        end
        set_a(1'b0, 4'h0, 4'h0);
        set_b(1'b0, 4'h0, 4'h0);
        cycle();

        // Restart the sweep, then abort it partway through with an asynchronous reset.
        rstn_v[1] = 1'b0;
        model_reset(1);
        cycle();
        rstn_v[1] = 1'b1;
        for (int k = 0; k < 10; k++) cycle();
        #2;
        rstn_v[1] = 1'b0;
        #1;
        chk("abort_wre",  1, {3'b0, wre_o[1]},  4'h0);
        chk("abort_busy", 1, {3'b0, busy_o[1]}, 4'h1);
        chk("abort_wad",  1, wad_o[1], 4'h0);
        model_reset(1);
        cycle();
        rstn_v[1] = 1'b1;
        for (int k = 0; k < 18; k++) cycle();

        // dut0 (no sweep): a request is taken in the very first cycle after release.
        rstn_v[1] = 1'b0;
        model_reset(1);
        set_a(1'b1, 4'hC, 4'h9);
        rstn_v[0] = 1'b1;
        cycle();
        chk("req044_wad", 0, wad_o[0], 4'hC);
        chk("req044_wd",  0, wd_o[0],  4'h9);
        set_a(1'b0, 4'h0, 4'h0);
        cycle();

        // Both held for four cycles after a fresh reset: A, B, A, B with no gaps.
        rstn_v[0] = 1'b0;
        model_reset(0);
        set_a(1'b1, 4'h1, 4'h6);
        set_b(1'b1, 4'hE, 4'h3);
        cycle();
        rstn_v[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("req041_wre", 0, {3'b0, wre_o[0]}, 4'h1);
            chk("req041_wad", 0, wad_o[0], (k % 2 == 0) ? 4'h1 : 4'hE);
        end
        set_a(1'b0, 4'h0, 4'h0);
        set_b(1'b0, 4'h0, 4'h0);
        cycle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dram16x4_wr_sched.md
DRAM16X4_WR_SCHED -- requirements
Module: dram16x4_wr_sched

Interface
REQ-001 SHALL provide parameter INIT_EN, default 1, meaning: 1 = clear all 16 locations after reset; 0 = skip clearing.
REQ-002 SHALL provide parameter INIT_VAL, default 4'h0, meaning: data word written to every location during clearing.
REQ-003 SHALL provide port CLK, input, 1, meaning: single clock; all state updates on its rising edge.
REQ-004 SHALL provide port RSTN, input, 1, meaning: reset, asynchronous, active-low.
REQ-005 SHALL provide port A_VALID, input, 1, meaning: requester A holds a write request.
REQ-006 SHALL provide port A_ADDR, input, 4, meaning: requester A write address.
REQ-007 SHALL provide port A_DATA, input, 4, meaning: requester A write data.
REQ-008 SHALL provide port A_READY, output, 1, meaning: requester A request accepted this cycle.
REQ-009 SHALL provide ports B_VALID (input, 1), B_ADDR (input, 4), B_DATA (input, 4) and B_READY (output, 1), meaning: requester B, same semantics as A.
REQ-010 SHALL provide port WAD, output, 4, meaning: RAM write address, driving the write-address mux WAD0..WAD3.
REQ-011 SHALL provide port WD, output, 4, meaning: RAM write data, driving the write-data mux WD0..WD3.
REQ-012 SHALL provide port WRE, output, 1, meaning: RAM write enable.
REQ-013 SHALL provide port BUSY, output, 1, meaning: clearing in progress.
REQ-014 SHALL provide port LAST_B, output, 1, meaning: last accepted write came from B.

Function
REQ-015 SHALL have exactly two states: CLEAR and RUN.
REQ-016 In CLEAR, SHALL drive WRE=1, WAD=cnt and WD=INIT_VAL as registered outputs, with a 4-bit cnt counting 0..15.
REQ-017 In CLEAR, SHALL hold BUSY=1, A_READY=0 and B_READY=0.
REQ-018 SHALL leave CLEAR for RUN on the edge where cnt=15 is written, i.e. the 16th WRE cycle.
REQ-019 SHALL never let cnt wrap back to 0 while in CLEAR.
REQ-020 In RUN, SHALL keep BUSY=0 and SHALL never return to CLEAR except via reset.
REQ-021 A_READY and B_READY SHALL be combinational from VALIDs, state and LAST_B.
REQ-022 At most one READY SHALL be high per cycle.
REQ-023 A request SHALL be accepted when VALID=1 and READY=1 in the same cycle.
REQ-024 In RUN with only one VALID high, SHALL grant that requester.
REQ-025 In RUN with both VALIDs high, SHALL grant A when LAST_B=1 and B when LAST_B=0 (round-robin).
REQ-026 On acceptance, SHALL present the accepted ADDR/DATA on WAD/WD with WRE=1 on the next cycle (latency 1 clock).
REQ-027 On acceptance, SHALL update LAST_B to the winner on the same edge.
REQ-028 In RUN with no acceptance, SHALL drive WRE=0 on the next cycle and hold WAD/WD at their previous values.
REQ-029 Back-to-back acceptances SHALL sustain one write per cycle with no bubble.
REQ-030 Both requesters targeting the same address on consecutive grants SHALL produce two writes in grant order, later data last.
REQ-031 A requester that is not granted SHALL keep VALID/ADDR/DATA stable until READY; the block SHALL not buffer ungranted requests.
REQ-032 All ADDR values 0..15 SHALL pass unchanged; no address arithmetic except cnt in CLEAR.

Reset
REQ-033 RSTN low SHALL asynchronously force WAD=0, WD=0, WRE=0, LAST_B=1 (A wins first tie) and cnt=0.
REQ-034 RSTN low SHALL set state=CLEAR if INIT_EN=1, else RUN.
REQ-035 While RSTN=0, SHALL drive BUSY=INIT_EN and A_READY=B_READY=0.
REQ-036 Reset asserted mid-CLEAR or mid-burst SHALL abort immediately; any pending registered write SHALL be dropped (WRE=0).
REQ-037 On RSTN release, clearing SHALL restart at address 0.
REQ-038 RSTN release SHALL be synchronised externally; the block SHALL assume nothing further.

Verification
REQ-039 Bench SHALL cover: INIT_EN=1, INIT_VAL=4'hA, release reset -> exactly 16 WRE cycles with WAD 0..15 and WD=A, BUSY falling after the 16th, with no READY during them.
REQ-040 Bench SHALL cover: RUN, A_VALID only, A_ADDR=3, A_DATA=5 -> A_READY=1 same cycle, next cycle WAD=3, WD=5, WRE=1, LAST_B=0.
REQ-041 Bench SHALL cover: both VALID held for 4 cycles after reset -> grants A,B,A,B with WRE=1 on 4 consecutive cycles.
REQ-042 Bench SHALL cover: A and B both addressing 7 with data 1 and 2, A winning -> WAD=7 written with 1 then 2 on consecutive cycles.
REQ-043 Bench SHALL cover: RSTN pulsed low at cnt=9 during CLEAR -> WRE=0 immediately, then after release 16 fresh writes starting at WAD=0.
REQ-044 Bench SHALL cover: INIT_EN=0, reset release -> BUSY=0 and a VALID request is accepted in the first cycle.
